multi_mode_cmd_controller: RTL and testbench

//  Parametrised front-panel command controller for NUM_MODES display modes.

---
 rtl/multi_mode_cmd_controller_if.sv | 28 ++
 rtl/multi_mode_cmd_controller.sv | 151 +++++++++++++++
 tb/tb_multi_mode_cmd_controller.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_mode_cmd_controller_if.sv
// Front-panel command bus: debounced buttons and per-mode display data in,
// current mode, display value and per-mode run/clear flags out.
interface multi_mode_cmd_controller_if #(
    parameter int NUM_MODES = 4,
    parameter int DATA_W    = 14
);
    localparam int MODE_W = $clog2(NUM_MODES);

    logic                        btnU;
    logic                        btnC;
    logic                        btnD;
    logic [NUM_MODES*DATA_W-1:0] mode_data;
    logic [MODE_W-1:0]           mode;
    logic [DATA_W-1:0]           seg_data;
    logic [NUM_MODES-1:0]        run_stop;
    logic [NUM_MODES-1:0]        clear;
    logic                        anim_mode;

    modport master (
        output btnU, btnC, btnD, mode_data,
        input  mode, seg_data, run_stop, clear, anim_mode
    );

    modport slave (
        input  btnU, btnC, btnD, mode_data,
        output mode, seg_data, run_stop, clear, anim_mode
    );
endinterface

// File: rtl/multi_mode_cmd_controller.sv
// Front-panel mode controller: button edge events, long-press global clear,
// idle timeout back to mode 0 and per-mode display value selection.
module multi_mode_cmd_controller #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int NUM_MODES     = 4,
    parameter int DATA_W        = 14,
    parameter int TIMEOUT_S     = 30,
    parameter int LONG_PRESS_MS = 1000
) (
    input logic                        clk,
    input logic                        reset,
    multi_mode_cmd_controller_if.slave bus
);
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int PRE_N  = CLK_HZ / 1000;
    localparam int PRE_W  = $clog2(PRE_N + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_MS + 1);
    localparam int IDLE_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_N - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_MS);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_MS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_S);
    localparam logic [IDLE_W-1:0] IDLE_FIRE = IDLE_W'(TIMEOUT_S - 1);

    logic                 prev_u_q, prev_c_q, prev_d_q;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [9:0]           ms_q, ms_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [NUM_MODES-1:0] run_q, run_d;
    logic [NUM_MODES-1:0] clr_q, clr_d;
    logic [DATA_W-1:0]    seg_q, seg_d;
    logic                 anim_q, anim_d;

    logic ev_u, ev_c, ev_d;
    logic ms_tick, sec_tick;
    logic long_press, idle_hold, timeout;

    always_comb begin
        ev_u       = bus.btnU & ~prev_u_q;
        ev_c       = bus.btnC & ~prev_c_q;
        ev_d       = bus.btnD & ~prev_d_q;
        ms_tick    = (pre_q == PRE_LAST);
        sec_tick   = ms_tick && (ms_q == 10'd999);
        long_press = bus.btnD && ms_tick && (hold_q == HOLD_FIRE);
        idle_hold  = (mode_q == '0) || run_q[mode_q];
        timeout    = (TIMEOUT_S > 0) && !idle_hold && sec_tick &&
                     (idle_q == IDLE_FIRE);
    end

    // Free-running ms/s time base; the hold counter saturates so a
    // long press can only fire once per hold.
    always_comb begin
        pre_d = ms_tick ? '0 : pre_q + PRE_W'(1);
        ms_d  = ms_q;
        if (ms_tick) begin
            ms_d = (ms_q == 10'd999) ? '0 : ms_q + 10'd1;
        end
        hold_d = '0;
        if (bus.btnD) begin
            hold_d = hold_q;
            if (ms_tick && hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (long_press) begin
            mode_d = '0;
        end else if (ev_u) begin
            mode_d = (mode_q == LAST_MODE) ? '0 : mode_q + MODE_W'(1);
        end else if (timeout) begin
            mode_d = '0;
        end

        run_d = run_q;
        if (ev_c && mode_q != '0) begin
            run_d[mode_q] = ~run_q[mode_q];
        end
        if (long_press) begin
            run_d = '0;
        end

        clr_d = '0;
        if (ev_d) begin
            clr_d[mode_q] = 1'b1;
        end
        if (long_press) begin
            clr_d = '1;
        end

        idle_d = idle_q;
        if (idle_hold || ev_u || ev_c || ev_d || mode_d != mode_q) begin
            idle_d = '0;
        end else if (sec_tick && idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        anim_d = (mode_d == '0);
    end

    always_comb begin
        seg_d = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode_q == MODE_W'(m)) begin
                seg_d = bus.mode_data[m*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_u_q <= 1'b0;
            prev_c_q <= 1'b0;
            prev_d_q <= 1'b0;
            pre_q    <= '0;
            ms_q     <= '0;
            hold_q   <= '0;
            idle_q   <= '0;
            mode_q   <= '0;
            run_q    <= '0;
            clr_q    <= '0;
            seg_q    <= '0;
            anim_q   <= 1'b1;
        end else begin
            prev_u_q <= bus.btnU;
            prev_c_q <= bus.btnC;
            prev_d_q <= bus.btnD;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
            hold_q   <= hold_d;
            idle_q   <= idle_d;
            mode_q   <= mode_d;
            run_q    <= run_d;
            clr_q    <= clr_d;
            seg_q    <= seg_d;
            anim_q   <= anim_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.seg_data  = seg_q;
    assign bus.run_stop  = run_q;
    assign bus.clear     = clr_q;
    assign bus.anim_mode = anim_q;
endmodule

// File: tb/tb_multi_mode_cmd_controller.sv
// Bench for multi_mode_cmd_controller: 4-mode and 3-mode instances checked
// against a cycle model, a vector table and directed timing sequences.
module tb_multi_mode_cmd_controller;
    localparam int CLK_HZ = 10_000;
    localparam int DW     = 14;
    localparam int TS     = 3;
    localparam int LP     = 5;
    localparam int PRE    = CLK_HZ / 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit bu[2];
    bit bc[2];
    bit bd[2];
    logic [4*DW-1:0] md4;
    logic [3*DW-1:0] md3;
    logic [DW-1:0]   data[2][4];

    multi_mode_cmd_controller_if #(.NUM_MODES(4), .DATA_W(DW)) if4 ();
    multi_mode_cmd_controller_if #(.NUM_MODES(3), .DATA_W(DW)) if3 ();

    assign if4.btnU      = bu[0];
    assign if4.btnC      = bc[0];
    assign if4.btnD      = bd[0];
    assign if4.mode_data = md4;
    assign if3.btnU      = bu[1];
    assign if3.btnC      = bc[1];
    assign if3.btnD      = bd[1];
    assign if3.mode_data = md3;

    multi_mode_cmd_controller #(
        .CLK_HZ(CLK_HZ), .NUM_MODES(4), .DATA_W(DW),
        .TIMEOUT_S(TS), .LONG_PRESS_MS(LP)
    ) dut4 (.clk(clk), .reset(rst), .bus(if4.slave));

    multi_mode_cmd_controller #(
        .CLK_HZ(CLK_HZ), .NUM_MODES(3), .DATA_W(DW),
        .TIMEOUT_S(TS), .LONG_PRESS_MS(LP)
    ) dut3 (.clk(clk), .reset(rst), .bus(if3.slave));

    int nchk = 0;
    int nerr = 0;
    int ncyc = 0;

    int       m_mode[2];
    bit [3:0] m_run[2];
    bit [3:0] m_clr[2];
    bit [DW-1:0] m_seg[2];
    bit       m_anim[2];
    bit       pu[2], pc[2], pd[2];
    int       held_ms[2];
    int       idle_s[2];

    logic [31:0] a_mode, a_seg, a_run, a_clr, a_anim;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, ncyc);
        end
    endtask

    task automatic sample(input int i);
        if (i == 0) begin
            a_mode = 32'(if4.mode);
            a_seg  = 32'(if4.seg_data);
            a_run  = 32'(if4.run_stop);
            a_clr  = 32'(if4.clear);
            a_anim = 32'(if4.anim_mode);
        end else begin
            a_mode = 32'(if3.mode);
            a_seg  = 32'(if3.seg_data);
            a_run  = 32'(if3.run_stop);
            a_clr  = 32'(if3.clear);
            a_anim = 32'(if3.anim_mode);
        end
    endtask

    // One clock edge of the panel, straight from the behavioural rules:
    // time is counted in whole cycles since reset.
    task automatic model_edge(input int i);
        int nm, nmode;
        bit eu, ec, ed, ms_e, sec_e, lp, to;
        bit [3:0] nrun, nclr;
        nm = (i == 0) ? 4 : 3;
        if (rst) begin
            m_mode[i] = 0; m_run[i] = '0; m_clr[i] = '0;
            m_seg[i] = '0; m_anim[i] = 1'b1;
            pu[i] = 0; pc[i] = 0; pd[i] = 0;
            held_ms[i] = 0; idle_s[i] = 0;
        end else begin
            eu    = bu[i] && !pu[i];
            ec    = bc[i] && !pc[i];
            ed    = bd[i] && !pd[i];
            ms_e  = (ncyc % PRE) == PRE - 1;
            sec_e = (ncyc % CLK_HZ) == CLK_HZ - 1;
            lp    = bd[i] && ms_e && held_ms[i] == LP - 1;
            to    = m_mode[i] != 0 && !m_run[i][m_mode[i]] && sec_e &&
                    idle_s[i] == TS - 1;
            nmode = lp ? 0 : eu ? (m_mode[i] + 1) % nm : to ? 0 : m_mode[i];
            nrun = m_run[i];
            if (ec && m_mode[i] != 0) nrun[m_mode[i]] = ~nrun[m_mode[i]];
            if (lp) nrun = '0;
            nclr = '0;
            if (ed) nclr[m_mode[i]] = 1'b1;
            if (lp) nclr = 4'((1 << nm) - 1);
            if (m_mode[i] == 0 || m_run[i][m_mode[i]] || eu || ec || ed ||
                nmode != m_mode[i])
                idle_s[i] = 0;
            else if (sec_e && idle_s[i] < TS)
                idle_s[i]++;
            if (!bd[i]) held_ms[i] = 0;
            else if (ms_e && held_ms[i] < LP) held_ms[i]++;
            m_seg[i]  = data[i][m_mode[i]];
            m_anim[i] = (nmode == 0);
            m_mode[i] = nmode;
            m_run[i]  = nrun;
            m_clr[i]  = nclr;
            pu[i] = bu[i]; pc[i] = bc[i]; pd[i] = bd[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        if (rst) ncyc = 0;
        else ncyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            sample(i);
            chk($sformatf("u%0d.mode", i), a_mode, 32'(m_mode[i]));
            chk($sformatf("u%0d.seg", i), a_seg, 32'(m_seg[i]));
            chk($sformatf("u%0d.run", i), a_run, 32'(m_run[i]));
            chk($sformatf("u%0d.clear", i), a_clr, 32'(m_clr[i]));
            chk($sformatf("u%0d.anim", i), a_anim, 32'(m_anim[i]));
        end
    endtask

    task automatic chk_reset(input int i);
        sample(i);
        chk($sformatf("rst%0d.mode", i), a_mode, 0);
        chk($sformatf("rst%0d.seg", i), a_seg, 0);
        chk($sformatf("rst%0d.run", i), a_run, 0);
        chk($sformatf("rst%0d.clear", i), a_clr, 0);
        chk($sformatf("rst%0d.anim", i), a_anim, 1);
    endtask

    typedef struct {
        bit       u, c, d;
        int       mode;
        bit [3:0] run;
        bit [3:0] clr;
        bit       anim;
    } vec_t;

    initial begin
        vec_t tv[14];
        int   pm, pulses, at, fired;
        int   wrap_exp[3];

        tv[0]  = '{1, 0, 0, 1, 4'b0000, 4'b0000, 0};
        tv[1]  = '{0, 0, 0, 1, 4'b0000, 4'b0000, 0};
        tv[2]  = '{1, 0, 0, 2, 4'b0000, 4'b0000, 0};
        tv[3]  = '{0, 0, 0, 2, 4'b0000, 4'b0000, 0};
        tv[4]  = '{0, 1, 0, 2, 4'b0100, 4'b0000, 0};
        tv[5]  = '{0, 0, 0, 2, 4'b0100, 4'b0000, 0};
        tv[6]  = '{1, 0, 0, 3, 4'b0100, 4'b0000, 0};
        tv[7]  = '{0, 0, 0, 3, 4'b0100, 4'b0000, 0};
        tv[8]  = '{0, 1, 0, 3, 4'b1100, 4'b0000, 0};
        tv[9]  = '{0, 0, 0, 3, 4'b1100, 4'b0000, 0};
        tv[10] = '{1, 0, 0, 0, 4'b1100, 4'b0000, 1};
        tv[11] = '{0, 0, 0, 0, 4'b1100, 4'b0000, 1};
        tv[12] = '{0, 1, 0, 0, 4'b1100, 4'b0000, 1};
        tv[13] = '{0, 0, 0, 0, 4'b1100, 4'b0000, 1};
        wrap_exp = '{1, 2, 0};

        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 4; m++)
                data[i][m] = DW'($urandom);
        for (int m = 0; m < 4; m++) md4[m*DW +: DW] = data[0][m];
        for (int m = 0; m < 3; m++) md3[m*DW +: DW] = data[1][m];

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // random button activity with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(7) == 0) bu[i] = ~bu[i];
                if ($urandom_range(7) == 0) bc[i] = ~bc[i];
                if ($urandom_range(39) == 0) bd[i] = ~bd[i];
            end
            rst = ($urandom_range(999) == 0);
            step();
        end

        bu = '{0, 0}; bc = '{0, 0}; bd = '{0, 0};
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset(0);
        chk_reset(1);

        // mode cycling, seg lag, run toggles, ignored btnC in mode 0
        pm = 0;
        for (int j = 0; j < 14; j++) begin
            bu[0] = tv[j].u; bc[0] = tv[j].c; bd[0] = tv[j].d;
            step();
            sample(0);
            chk($sformatf("tv%0d.mode", j), a_mode, 32'(tv[j].mode));
            chk($sformatf("tv%0d.run", j), a_run, 32'(tv[j].run));
            chk($sformatf("tv%0d.clear", j), a_clr, 32'(tv[j].clr));
            chk($sformatf("tv%0d.anim", j), a_anim, 32'(tv[j].anim));
            chk($sformatf("tv%0d.seg", j), a_seg, 32'(data[0][pm]));
            pm = tv[j].mode;
        end
        bu[0] = 0; bc[0] = 0;

        // short btnD hold in mode 1
        bu[0] = 1; step(); bu[0] = 0; step();
        chk("t3.mode", 32'(if4.mode), 1);
        bd[0] = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t3.clear", 32'(if4.clear), (k == 0) ? 32'h2 : 32'h0);
        end
        bd[0] = 0; step();

        // long press in running mode 3
        for (int k = 0; k < 2; k++) begin
            bu[0] = 1; step(); bu[0] = 0; step();
        end
        chk("t4.mode", 32'(if4.mode), 3);
        chk("t4.run", 32'(if4.run_stop), 32'hc);
        bd[0] = 1;
        pulses = 0; at = -1;
        for (int k = 0; k < 80; k++) begin
            step();
            if (k == 0) chk("t4.press", 32'(if4.clear), 32'h8);
            if (if4.clear == 4'b1111) begin
                pulses++; at = k;
                chk("t4.lp_mode", 32'(if4.mode), 0);
                chk("t4.lp_run", 32'(if4.run_stop), 0);
            end
        end
        chk("t4.pulses", 32'(pulses), 1);
        chk("t4.lp_at", 32'(at >= 40 && at <= 49), 1);
        bd[0] = 0; step();

        // idle timeout: u3 idle in mode 1, u4 running in mode 1
        bu[0] = 1; bu[1] = 1; step(); bu[0] = 0; bu[1] = 0; step();
        bc[0] = 1; step(); bc[0] = 0; step();
        chk("t5.u4mode", 32'(if4.mode), 1);
        chk("t5.u4run", 32'(if4.run_stop), 32'h2);
        chk("t5.u3mode", 32'(if3.mode), 1);
        while (ncyc < 29999) step();
        chk("t5.pre_to", 32'(if3.mode), 1);
        step();
        chk("t5.timeout", 32'(if3.mode), 0);
        chk("t5.running", 32'(if4.mode), 1);

        // stop u4 and let it idle; u3 wraps 2 -> 0
        bc[0] = 1; step(); bc[0] = 0; step();
        chk("t5.stop", 32'(if4.run_stop), 0);
        for (int k = 0; k < 3; k++) begin
            bu[1] = 1; step(); bu[1] = 0; step();
            chk($sformatf("wrap%0d", k), 32'(if3.mode), 32'(wrap_exp[k]));
        end
        while (ncyc < 45000) step();
        bu[1] = 1; step(); bu[1] = 0;
        while (ncyc < 59999) step();
        chk("t5.pre_u", 32'(if4.mode), 1);
        bu[0] = 1; step(); bu[0] = 0;
        chk("t5.u_at_to", 32'(if4.mode), 2);

        // reset mid long-press (u4) and mid idle count (u3)
        bd[0] = 1;
        repeat (30) step();
        rst = 1'b1;
        step();
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        fired = -1;
        for (int k = 0; k < 80; k++) begin
            step();
            if (if4.clear == 4'b1111 && fired < 0) fired = ncyc;
        end
        chk("t6.lp_after_rst", 32'(fired), 50);
        chk("t6.u3mode", 32'(if3.mode), 0);
        bd[0] = 0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
